// File: rtl/fwrisc_mem_arb_pkg.sv
// Shared types for the FWRISC single-port memory arbiter.
// FSM state and port-identifier enums used by the arbiter and its sub-block.
package fwrisc_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_ACC,
    D_ACC
  } arb_state_e;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_e;

  localparam logic [3:0] BE_ALL = 4'hf;

endpackage

// File: rtl/fwrisc_mem_arbiter_if.sv
// Core-side instruction/data bus of the FWRISC memory arbiter.
// master: core (drives requests); slave: arbiter (returns data/ready).
interface fwrisc_mem_arbiter_if;

  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] idata;
  logic        iready;

  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic        dwrite;
  logic        dvalid;
  logic [31:0] drdata;
  logic        dready;

  modport master (
    output iaddr, ivalid,
    output daddr, dwdata, dwstb, dwrite, dvalid,
    input  idata, iready,
    input  drdata, dready
  );

  modport slave (
    input  iaddr, ivalid,
    input  daddr, dwdata, dwstb, dwrite, dvalid,
    output idata, iready,
    output drdata, dready
  );

endinterface

// File: rtl/fwrisc_rr_arb2.sv
// Two-requester round-robin grant (combinational).
// req[PORT_I]/req[PORT_D], last_grant in; grant out (don't-care if no req).
module fwrisc_rr_arb2
  import fwrisc_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_port_e  last_grant,
  output arb_port_e  grant
);

  always_comb begin
    grant = PORT_I;
    unique case (req)
      2'b10: grant = PORT_D;
      2'b11: begin
        if (last_grant == PORT_I) grant = PORT_D;
        else                      grant = PORT_I;
      end
      default: grant = PORT_I;
    endcase
  end

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// Shares one byte-enabled sync SRAM between FWRISC I and D ports.
// Ports: clock, reset, bus (slave), sram_addr/wdata/be/we out, sram_rdata in.
module fwrisc_mem_arbiter
  import fwrisc_mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 14
) (
  input  logic                     clock,
  input  logic                     reset,
  fwrisc_mem_arbiter_if.slave      bus,
  output logic [ADDRESS_WIDTH-1:0] sram_addr,
  output logic [31:0]              sram_wdata,
  output logic [3:0]               sram_be,
  output logic                     sram_we,
  input  logic [31:0]              sram_rdata
);

  arb_state_e state;
  arb_port_e  last_grant;
  arb_port_e  grant;
  logic [1:0] req;
  logic       launch;
  logic       unused_addr_bits;

  assign req = {bus.dvalid, bus.ivalid};

  fwrisc_rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // SRAM samples the address at the end of the launch cycle, so the
  // launch drive must be combinational for data to arrive at N+1.
  assign launch = (state == IDLE) && (|req) && !reset;

  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_be    = '0;
    sram_we    = 1'b0;
    if (launch) begin
      if (grant == PORT_D) begin
        sram_addr = bus.daddr[ADDRESS_WIDTH+1:2];
        if (bus.dwrite) begin
          sram_we    = 1'b1;
          sram_be    = bus.dwstb;
          sram_wdata = bus.dwdata;
        end else begin
          sram_be = BE_ALL;
        end
      end else begin
        sram_addr = bus.iaddr[ADDRESS_WIDTH+1:2];
        sram_be   = BE_ALL;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= PORT_I;
    end else begin
      unique case (state)
        IDLE: begin
          if (launch) begin
            last_grant <= grant;
            if (grant == PORT_D) state <= D_ACC;
            else                 state <= I_ACC;
          end
        end
        I_ACC:   state <= IDLE;
        D_ACC:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is a state decode; reset squashes a pulse in flight.
  assign bus.iready = (state == I_ACC) && !reset;
  assign bus.dready = (state == D_ACC) && !reset;
  assign bus.idata  = sram_rdata;
  assign bus.drdata = sram_rdata;

  assign unused_addr_bits = ^{bus.iaddr[31:ADDRESS_WIDTH+2],
                              bus.iaddr[1:0],
                              bus.daddr[31:ADDRESS_WIDTH+2],
                              bus.daddr[1:0]};

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Directed self-checking bench for fwrisc_mem_arbiter.
// Includes a byte-enabled sync SRAM model with a preload port.
module tb_fwrisc_mem_arbiter;

  logic        clock;
  logic        reset;
  logic [13:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic        sram_we;
  logic [31:0] sram_rdata;

  logic        load_en;
  logic [13:0] load_a;
  logic [31:0] load_d;
  logic [31:0] mem [0:16383];

  int n_cmp;
  int n_err;

  fwrisc_mem_arbiter_if bus ();

  fwrisc_mem_arbiter #(.ADDRESS_WIDTH(14)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_be    (sram_be),
    .sram_we    (sram_we),
    .sram_rdata (sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (load_en) begin
      mem[load_a] <= load_d;
    end else if (sram_we) begin
      for (int b = 0; b < 4; b++)
        if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
    sram_rdata <= mem[sram_addr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [13:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_a  = a;
    load_d  = d;
    tick();
    load_en = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    load_en = 1'b0;
    load_a = '0;
    load_d = '0;
    bus.iaddr = '0;
    bus.ivalid = 1'b0;
    bus.daddr = '0;
    bus.dwdata = '0;
    bus.dwstb = '0;
    bus.dwrite = 1'b0;
    bus.dvalid = 1'b0;
    repeat (2) tick();

    load(14'h0000, 32'h0BAD_F00D);
    load(14'h0040, 32'hDEAD_BEEF);
    load(14'h0081, 32'h1122_3344);
    for (int i = 0; i < 4; i++)
      load(14'h0100 + 14'(i), 32'hC0DE_0000 + 32'(i));

    // reset values
    @(negedge clock);
    check("rst_iready", 32'(bus.iready), 32'h0);
    check("rst_dready", 32'(bus.dready), 32'h0);
    check("rst_we", 32'(sram_we), 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_be", 32'(sram_be), 32'h0);
    check("rst_wdata", sram_wdata, 32'h0);

    // single fetch
    tick();
    reset = 1'b0;
    bus.ivalid = 1'b1;
    bus.iaddr = 32'h0000_0100;
    @(negedge clock);
    check("f_addr", 32'(sram_addr), 32'h40);
    check("f_be", 32'(sram_be), 32'hf);
    check("f_we0", 32'(sram_we), 32'h0);
    check("f_rdy0", 32'(bus.iready), 32'h0);
    tick();
    @(negedge clock);
    check("f_rdy1", 32'(bus.iready), 32'h1);
    check("f_data", bus.idata, 32'hDEAD_BEEF);
    check("f_we1", 32'(sram_we), 32'h0);
    tick();
    bus.ivalid = 1'b0;

    // byte write
    bus.dvalid = 1'b1;
    bus.dwrite = 1'b1;
    bus.daddr = 32'h0000_0204;
    bus.dwstb = 4'b0010;
    bus.dwdata = 32'h0000_AB00;
    @(negedge clock);
    check("w_we", 32'(sram_we), 32'h1);
    check("w_addr", 32'(sram_addr), 32'h81);
    check("w_be", 32'(sram_be), 32'h2);
    check("w_wdata", sram_wdata, 32'h0000_AB00);
    check("w_rdy0", 32'(bus.dready), 32'h0);
    tick();
    @(negedge clock);
    check("w_rdy1", 32'(bus.dready), 32'h1);
    check("w_we_off", 32'(sram_we), 32'h0);
    tick();

    // read back
    bus.dwrite = 1'b0;
    @(negedge clock);
    check("r_we", 32'(sram_we), 32'h0);
    check("r_be", 32'(sram_be), 32'hf);
    tick();
    @(negedge clock);
    check("r_rdy", 32'(bus.dready), 32'h1);
    check("r_data", bus.drdata, 32'h1122_AB44);
    tick();

    // address wrap
    bus.daddr = 32'h0001_0000;
    @(negedge clock);
    check("wrap_addr", 32'(sram_addr), 32'h0);
    tick();
    @(negedge clock);
    check("wrap_rdy", 32'(bus.dready), 32'h1);
    check("wrap_data", bus.drdata, 32'h0BAD_F00D);
    tick();
    bus.dvalid = 1'b0;

    // back-to-back fetches
    bus.ivalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.iaddr = 32'h0000_0400 + 32'(4 * i);
      @(negedge clock);
      check("b2b_launch", 32'(bus.iready), 32'h0);
      tick();
      @(negedge clock);
      check("b2b_rdy", 32'(bus.iready), 32'h1);
      check("b2b_data", bus.idata, 32'hC0DE_0000 + 32'(i));
      tick();
    end
    bus.ivalid = 1'b0;

    // tie-break from reset release
    reset = 1'b1;
    bus.ivalid = 1'b1;
    bus.dvalid = 1'b1;
    bus.dwrite = 1'b0;
    bus.iaddr = 32'h0000_0100;
    bus.daddr = 32'h0000_0204;
    @(negedge clock);
    check("tie_rst_we", 32'(sram_we), 32'h0);
    check("tie_rst_addr", 32'(sram_addr), 32'h0);
    check("tie_rst_rdy", 32'({bus.iready, bus.dready}), 32'h0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check("tie_irdy", 32'(bus.iready), 32'((c % 4) == 3));
      check("tie_drdy", 32'(bus.dready), 32'((c % 4) == 1));
      if ((c % 4) == 0) check("tie_daddr", 32'(sram_addr), 32'h81);
      if ((c % 4) == 2) check("tie_iaddr", 32'(sram_addr), 32'h40);
      if ((c % 4) == 1) check("tie_ddata", bus.drdata, 32'h1122_AB44);
      if ((c % 4) == 3) check("tie_idata", bus.idata, 32'hDEAD_BEEF);
      tick();
    end

    // reset during D_ACC
    bus.ivalid = 1'b0;
    bus.dvalid = 1'b1;
    bus.dwrite = 1'b1;
    bus.daddr = 32'h0000_0208;
    bus.dwstb = 4'hf;
    bus.dwdata = 32'h5566_7788;
    @(negedge clock);
    check("mr_we", 32'(sram_we), 32'h1);
    tick();
    reset = 1'b1;
    bus.dvalid = 1'b0;
    @(negedge clock);
    check("mr_drdy", 32'(bus.dready), 32'h0);
    check("mr_we0", 32'(sram_we), 32'h0);
    check("mr_addr", 32'(sram_addr), 32'h0);
    tick();
    reset = 1'b0;
    bus.dvalid = 1'b1;
    bus.dwrite = 1'b0;
    @(negedge clock);
    check("mr_idle_d", 32'(bus.dready), 32'h0);
    check("mr_idle_i", 32'(bus.iready), 32'h0);
    check("mr_launch", 32'(sram_addr), 32'h82);
    tick();
    @(negedge clock);
    check("mr_rdy", 32'(bus.dready), 32'h1);
    check("mr_data", bus.drdata, 32'h5566_7788);
    tick();
    bus.dvalid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fwrisc_mem_arbiter.md
# fwrisc_mem_arbiter

Shares one single-port, byte-enabled synchronous SRAM between the FWRISC instruction port (iaddr/idata/ivalid/iready) and data port (daddr/dwdata/drdata/dwstb/dwrite/dvalid/dready). It sits between the `fwrisc` core and a `generic_sram_byte_en` instance in single-port system builds and unit benches. A two-state-per-access FSM handles the SRAM's one-cycle read latency. Round-robin arbitration resolves simultaneous requests.

## Interface
- ADDRESS_WIDTH, 14 — SRAM word-address width; byte address bits [ADDRESS_WIDTH+1:2] are used.
- clock  in  1  — single clock; all logic on posedge.
- reset  in  1  — synchronous, active-high.
- iaddr  in  32  — instruction byte address.
- ivalid  in  1  — instruction fetch request.
- idata  out  32  — fetch data; valid when iready=1.
- iready  out  1  — one-cycle fetch completion pulse.
- daddr  in  32  — data byte address.
- dwdata  in  32  — write data.
- dwstb  in  4  — write byte strobes.
- dwrite  in  1  — 1=write, 0=read; qualified by dvalid.
- dvalid  in  1  — data request.
- drdata  out  32  — read data; valid when dready=1 and dwrite=0.
- dready  out  1  — one-cycle data completion pulse.
- sram_addr  out  ADDRESS_WIDTH  — SRAM word address.
- sram_wdata  out  32  — SRAM write data.
- sram_be  out  4  — SRAM byte enables.
- sram_we  out  1  — SRAM write enable.
- sram_rdata  in  32  — SRAM read data, valid the cycle after address.

## Operation
- FSM states: IDLE, I_ACC, D_ACC.
- IDLE with no request: sram_we=0; stay in IDLE.
- IDLE with one request: launch it.
  - Drive sram_addr from that port.
  - Data write: sram_we=1, sram_be=dwstb, sram_wdata=dwdata.
  - Data read and fetch: sram_we=0, sram_be=4'hf.
  - Go to I_ACC or D_ACC.
- IDLE with both requests: grant the port not granted last (last_grant register); update last_grant on every launch.
- I_ACC: iready=1, idata=sram_rdata; next state IDLE.
- D_ACC: dready=1, drdata=sram_rdata (meaningless for writes); next state IDLE.
- Addresses are truncated to ADDRESS_WIDTH word bits. Out-of-range addresses wrap; no error is signalled.
- Requesters hold valid and payload until ready. The payload is sampled only in the launch cycle, so a valid dropped during x_ACC still completes. dwrite is likewise sampled only at launch.
- The instruction port never writes.
- The ready for a request and the launch of the next request never occur in the same cycle.

## Timing
- Reset values:
  - State IDLE; last_grant=I, so data wins the first tie.
  - iready=0, dready=0, sram_we=0.
  - sram_addr, sram_be, sram_wdata: 0.
  - idata, drdata follow sram_rdata.
- Latency: request sampled in IDLE at cycle N → ready at N+1.
- Throughput: one access per 2 cycles; idle requester loses no extra cycles.
- Continuous dual requests alternate D, I, D, I…; neither port starves (max wait 2 cycles extra).
- sram_we is asserted only in the launch cycle, exactly one cycle per write.
- Reset asserted in I_ACC/D_ACC: the next cycle is IDLE, no ready pulse. A write already launched has completed in the SRAM.
- ready is a registered-state decode: no combinational path from valid to ready.

## Structure
- Package fwrisc_mem_arb_pkg:
  - typedef enum logic [1:0] arb_state_e {IDLE, I_ACC, D_ACC}.
  - typedef enum logic arb_port_e {PORT_I, PORT_D}.
- Sub-module fwrisc_rr_arb2: inputs req[1:0] and last_grant; output grant. Purely combinational, reused by future multi-master builds.
- Top FSM and address/data muxing live in fwrisc_mem_arbiter.

## Test plan
- Single fetch: ivalid=1, iaddr=0x100, SRAM word 0x40=0xDEADBEEF → iready at N+1 with idata=0xDEADBEEF; sram_we never 1.
- Byte write then read: dvalid=1, dwrite=1, daddr=0x204, dwstb=4'b0010, dwdata=0x0000AB00 over word 0x11223344 → sram_we pulse one cycle, dready at N+1. Read-back gives 0x1122AB44.
- Tie-break: ivalid and dvalid both held high from reset release → launches D,I,D,I…; iready/dready each pulse every 4 cycles, offset by 2.
- Wrap: daddr=0x0001_0000 with ADDRESS_WIDTH=14 → sram_addr=0; read returns word 0.
- Reset mid-access: assert reset during D_ACC → dready stays 0, state IDLE next cycle, all outputs at reset values.
- Back-to-back fetches: ivalid held, iaddr stepping by 4 each iready → one iready every 2 cycles, data matches memory image.
